mem_access_controller_mp: RTL and testbench
===========================================

// Module: mem_access_controller_mp
// PURPOSE
//  Multi-port successor to the single-port memory access controller: NUM_PORTS requesters
//  (e.g. ifetch, load/store, debug) share one word-addressed on-chip memory through fair
//  round-robin arbitration. Adds configurable access latency, bit-masked writes and
//  per-port read responses. Sits between the CPU pipeline stages and the RAM array.
// PARAMETERS
//  NUM_PORTS    2      number of requester ports (1..8)
//  MEMORY_SIZE  4096   memory depth in 32-bit words (power of two)
//  MEMORY_FILE  ""     hex init file for $readmemh; empty = no init
//  LATENCY      1      cycles from accept to completion (1..15)
// PORTS
//  clk          in   1              clock, all logic on posedge
//  reset        in   1              synchronous, active-high reset
//  cmd_start    in   NUM_PORTS      per-port request strobe
//  cmd_write    in   NUM_PORTS      per-port 1=write 0=read
//  cmd_ready    out  NUM_PORTS      per-port: controller can accept this cycle
//  addr         in   NUM_PORTS*32   per-port byte address, port p at [32p+:32]
//  wdata        in   NUM_PORTS*32   per-port write data
//  wmask        in   NUM_PORTS*32   per-port bit write mask (1 = write bit)
//  rdata        out  NUM_PORTS*32   per-port read data, held until next response to port
//  rdata_valid  out  NUM_PORTS      per-port one-cycle read-response pulse
// BEHAVIOUR
//  - Reset: cmd_ready=0, rdata_valid=0, rdata=0, rr pointer=0, state IDLE. Memory array
//    NOT reset; loaded from MEMORY_FILE at elaboration only. cmd_ready=1 (all ports)
//    from first cycle after reset deasserts.
//  - States: IDLE (cmd_ready=all 1s) -> BUSY (cmd_ready=0, latency counter) -> IDLE.
//  - Accept: in IDLE, at an edge where any cmd_start[p]=1, grant the first requesting port
//    at or after rr pointer (wrapping); latch port id, write, addr, wdata, wmask; set
//    rr pointer = granted+1 mod NUM_PORTS; go BUSY, counter=LATENCY-1. Only one port
//    accepted per edge; losers keep cmd_start high and retry (no loss, no queue).
//  - Word index = addr[31:2] mod MEMORY_SIZE (upper bits ignored, wraps); addr[1:0] ignored.
//  - Completion: edge where counter==0 in BUSY. Write: mem[w] <= (mem[w]&~wmask)|(wdata&wmask);
//    no rdata_valid. Read: rdata[port] <= mem[w], rdata_valid[port]=1 for exactly one
//    cycle. Return to IDLE on the same edge: response cycle = cmd_ready cycle, so accept at
//    edge T gives rdata_valid during cycle T+LATENCY; next accept possible at edge T+LATENCY.
//  - Read-after-write same word: the later read returns written data (writes commit first).
//  - wmask=0 write completes normally with memory unchanged.
//  - cmd_start while cmd_ready=0 is ignored (requester must hold it).
//  - Reset during BUSY: request dropped, no memory write, no rdata_valid, back to IDLE.
//  - Other ports' rdata unchanged on a response.
// STRUCTURE
//  - Shared package mem_pkg: WORD_W=32, state enum {IDLE,BUSY}, port-id width function.
//  - Sub-module rr_arbiter (NUM_PORTS req/ptr -> one-hot grant + index), pure combinational.
//  - Memory array inferred as single-port sync RAM inside this module.
// TESTING
//  1 Reset then idle: after reset low, cmd_ready==2'b11, rdata_valid==0 for 10 cycles.
//  2 Port0 write addr 0x10 wdata 0xDEADBEEF wmask 0xFFFFFFFF, then port0 read 0x10
//    -> rdata[0]=0xDEADBEEF, rdata_valid[0] pulse exactly LATENCY cycles after accept.
//  3 Masked write 0x0000FFFF of 0x12345678 over 0xDEADBEEF -> read gives 0xDEAD5678.
//  4 Both ports cmd_start every cycle reading 0x0/0x4 -> grants alternate 0,1,0,1; each
//    port gets correct data, rdata_valid never on both ports at once.
//  5 Address wrap: write addr 4*MEMORY_SIZE+8 -> read addr 0x8 returns same data.
//  6 Assert reset mid-BUSY of a write to 0x20 -> no rdata_valid; later read of 0x20 shows
//    old contents; cmd_ready returns 1 after reset release.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the multi-port memory access controller.
// Latency: n/a. Backpressure: n/a.
// Holds the FSM state encoding, the latched-request struct and the port-id width helper.
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic              write;
        logic [WORD_W-1:0] addr;
        logic [WORD_W-1:0] wdata;
        logic [WORD_W-1:0] wmask;
    } req_t;

    function automatic int port_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_access_controller_mp_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after ptr, wrapping.
// Latency: combinational. Backpressure: none, a losing requester simply retries later.
// Emits both a one-hot grant and the matching port index.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDW       = port_id_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDW-1:0]       ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDW-1:0]       grant_idx
);

    function automatic int wrap_idx(input int base, input int k);
        return (base + k) % NUM_PORTS;
    endfunction

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (grant == '0 && req[wrap_idx(int'(ptr), k)]) begin
                grant[wrap_idx(int'(ptr), k)] = 1'b1;
                grant_idx                     = IDW'(wrap_idx(int'(ptr), k));
            end
        end
    end

endmodule

// File: rtl/mem_access_controller_mp.sv
// Multi-port word memory with round-robin access, masked writes and per-port read responses.
// Latency: LATENCY cycles from accept to completion. Backpressure: cmd_ready low while busy; requesters hold cmd_start.
// One request in flight at a time; read response and the next accept opportunity share a cycle.
module mem_access_controller_mp
    import mem_pkg::*;
#(
    parameter int    NUM_PORTS   = 2,
    parameter int    MEMORY_SIZE = 4096,
    parameter string MEMORY_FILE = "",
    parameter int    LATENCY     = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        cmd_start,
    input  logic [NUM_PORTS-1:0]        cmd_write,
    output logic [NUM_PORTS-1:0]        cmd_ready,
    input  logic [NUM_PORTS*WORD_W-1:0] addr,
    input  logic [NUM_PORTS*WORD_W-1:0] wdata,
    input  logic [NUM_PORTS*WORD_W-1:0] wmask,
    output logic [NUM_PORTS*WORD_W-1:0] rdata,
    output logic [NUM_PORTS-1:0]        rdata_valid
);

    localparam int IDW   = port_id_w(NUM_PORTS);
    localparam int AW    = $clog2(MEMORY_SIZE);
    localparam int CNT_W = 4;

    state_t               state, next_state;
    logic [CNT_W-1:0]     cnt;
    logic [IDW-1:0]       rr_ptr;
    logic [IDW-1:0]       cur_port;
    logic [IDW-1:0]       grant_idx;
    logic [NUM_PORTS-1:0] grant;
    req_t                 cur;
    logic [AW-1:0]        cur_word;
    logic                 accept;
    logic                 complete;
    logic                 mem_we;
    logic                 unused_addr_bits;

    logic [WORD_W-1:0] mem [MEMORY_SIZE];

    // Upper address bits beyond the array depth wrap; byte offset is ignored.
    assign cur_word         = cur.addr[AW+1:2];
    assign unused_addr_bits = ^{cur.addr[WORD_W-1:AW+2], cur.addr[1:0]};

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS),
        .IDW       (IDW)
    ) u_arb (
        .req       (cmd_start),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        complete   = 1'b0;
        cmd_ready  = '0;
        case (state)
            IDLE: begin
                cmd_ready = {NUM_PORTS{~reset}};
                if (|grant) begin
                    accept     = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rr_ptr      <= '0;
            cur_port    <= '0;
            cur         <= '0;
            rdata       <= '0;
            rdata_valid <= '0;
        end else begin
            state       <= next_state;
            rdata_valid <= '0;
            if (accept) begin
                cur_port <= grant_idx;
                cur      <= '{write: cmd_write[grant_idx],
                              addr:  addr[WORD_W*int'(grant_idx) +: WORD_W],
                              wdata: wdata[WORD_W*int'(grant_idx) +: WORD_W],
                              wmask: wmask[WORD_W*int'(grant_idx) +: WORD_W]};
                rr_ptr   <= (int'(grant_idx) == NUM_PORTS - 1) ? '0 : grant_idx + 1'b1;
                cnt      <= CNT_W'(LATENCY - 1);
            end else if (state == BUSY && !complete) begin
                cnt <= cnt - 1'b1;
            end
            if (complete && !cur.write) begin
                rdata[WORD_W*int'(cur_port) +: WORD_W] <= mem[cur_word];
                rdata_valid[cur_port]                  <= 1'b1;
            end
        end
    end

    // Array is deliberately outside the reset domain; a reset mid-request suppresses the write.
    assign mem_we = complete && cur.write && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[cur_word] <= (mem[cur_word] & ~cur.wmask) | (cur.wdata & cur.wmask);
        end
    end

endmodule

// File: tb/tb_mem_access_controller_mp.sv
// Directed plus randomized bench for mem_access_controller_mp against a word-array reference model.
module tb_mem_access_controller_mp;

    localparam int NP  = 2;
    localparam int MS  = 256;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NP-1:0]  cmd_start = '0;
    logic [NP-1:0]  cmd_write = '0;
    logic [NP*32-1:0] addr  = '0;
    logic [NP*32-1:0] wdata = '0;
    logic [NP*32-1:0] wmask = '0;
    logic [NP-1:0]  cmd_ready;
    logic [NP*32-1:0] rdata;
    logic [NP-1:0]  rdata_valid;

    int checks = 0;
    int errors = 0;
    int rr     = 0;
    logic [31:0] model [MS];

    mem_access_controller_mp #(
        .NUM_PORTS   (NP),
        .MEMORY_SIZE (MS),
        .MEMORY_FILE (""),
        .LATENCY     (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_start   (cmd_start),
        .cmd_write   (cmd_write),
        .cmd_ready   (cmd_ready),
        .addr        (addr),
        .wdata       (wdata),
        .wmask       (wmask),
        .rdata       (rdata),
        .rdata_valid (rdata_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[31:2]) % MS;
    endfunction

    task automatic wait_ready(input int p);
        int n = 0;
        while (cmd_ready[p] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 64'(cmd_ready[p]), 64'd1);
    endtask

    // Single access by one port; checks latency, pulse width, data and idle behaviour.
    task automatic access(input int p, input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] m);
        logic [31:0] other;
        int          wi;
        wi = widx(a);
        @(negedge clk);
        wait_ready(p);
        other              = rdata[32*(1-p) +: 32];
        cmd_start[p]       = 1'b1;
        cmd_write[p]       = w;
        addr[32*p +: 32]   = a;
        wdata[32*p +: 32]  = d;
        wmask[32*p +: 32]  = m;
        @(negedge clk);
        cmd_start[p] = 1'b0;
        rr = (p + 1) % NP;
        for (int n = 0; n < LAT; n++) begin
            chk("busy_valid", 64'(rdata_valid), 64'd0);
            chk("busy_ready", 64'(cmd_ready), 64'd0);
            @(negedge clk);
        end
        chk("done_ready", 64'(cmd_ready), 64'h3);
        if (w) begin
            chk("write_no_valid", 64'(rdata_valid), 64'd0);
            model[wi] = (model[wi] & ~m) | (d & m);
        end else begin
            chk("read_valid", 64'(rdata_valid), 64'(1 << p));
            chk("read_data", 64'(rdata[32*p +: 32]), 64'(model[wi]));
            chk("other_rdata_held", 64'(rdata[32*(1-p) +: 32]), 64'(other));
            @(negedge clk);
            chk("valid_one_cycle", 64'(rdata_valid), 64'd0);
        end
    endtask

    initial begin
        int got;
        int exp_port;
        int n;

        // Reset and idle
        repeat (3) @(negedge clk);
        chk("reset_ready", 64'(cmd_ready), 64'd0);
        chk("reset_valid", 64'(rdata_valid), 64'd0);
        chk("reset_rdata", 64'(rdata), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_ready", 64'(cmd_ready), 64'h3);
            chk("idle_valid", 64'(rdata_valid), 64'd0);
        end

        // Give words 0..15 known contents
        for (int i = 0; i < 16; i++)
            access(i % NP, 1'b1, 32'(i * 4), 32'hA5A5A5A5 ^ (32'(i) * 32'h01010101), 32'hFFFFFFFF);

        // Full write then read back, masked write, zero-mask write
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'hFFFFFFFF);
        access(0, 1'b0, 32'h10, 32'h0, 32'h0);
        chk("full_write_const", 64'(rdata[31:0]), 64'hDEADBEEF);
        access(0, 1'b1, 32'h10, 32'h12345678, 32'h0000FFFF);
        access(0, 1'b0, 32'h10, 32'h0, 32'h0);
        chk("masked_write_const", 64'(rdata[31:0]), 64'hDEAD5678);
        access(1, 1'b1, 32'h10, 32'hFFFFFFFF, 32'h00000000);
        access(1, 1'b0, 32'h10, 32'h0, 32'h0);
        chk("zero_mask_const", 64'(rdata[63:32]), 64'hDEAD5678);

        // Address wrap beyond the array depth
        access(1, 1'b1, 32'(4 * MS + 8), 32'hCAFEF00D, 32'hFFFFFFFF);
        access(0, 1'b0, 32'h8, 32'h0, 32'h0);
        chk("wrap_const", 64'(rdata[31:0]), 64'hCAFEF00D);

        // Both ports requesting continuously: grants must alternate
        @(negedge clk);
        wait_ready(0);
        cmd_write = '0;
        addr[31:0]  = 32'h0;
        addr[63:32] = 32'h4;
        cmd_start   = 2'b11;
        exp_port = rr;
        got = 0;
        n = 0;
        while (got < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (rdata_valid !== 2'b00) begin
                chk("arb_onehot", 64'($countones(rdata_valid)), 64'd1);
                chk("arb_order", 64'(rdata_valid), 64'(1 << exp_port));
                chk("arb_data", 64'(rdata[32*exp_port +: 32]), 64'(model[exp_port]));
                exp_port = (exp_port + 1) % NP;
                got++;
            end
        end
        cmd_start = 2'b00;
        rr = exp_port;
        chk("arb_count", 64'(got), 64'd4);
        @(negedge clk);
        chk("arb_drained_valid", 64'(rdata_valid), 64'd0);
        chk("arb_drained_ready", 64'(cmd_ready), 64'h3);

        // Randomized mix across aliased addresses of words 0..15
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 3) * MS * 4 + $urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            access(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, $urandom);
        end

        // Reset in the middle of a write
        @(negedge clk);
        wait_ready(0);
        cmd_start[0]  = 1'b1;
        cmd_write[0]  = 1'b1;
        addr[31:0]    = 32'h20;
        wdata[31:0]   = 32'h11112222;
        wmask[31:0]   = 32'hFFFFFFFF;
        @(negedge clk);
        cmd_start[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midreset_ready", 64'(cmd_ready), 64'd0);
            chk("midreset_valid", 64'(rdata_valid), 64'd0);
        end
        chk("midreset_rdata", 64'(rdata), 64'd0);
        reset = 1'b0;
        rr = 0;
        @(negedge clk);
        chk("post_reset_ready", 64'(cmd_ready), 64'h3);
        chk("post_reset_valid", 64'(rdata_valid), 64'd0);
        access(1, 1'b0, 32'h20, 32'h0, 32'h0);
        chk("dropped_write_const", 64'(rdata[63:32] == 32'h11112222), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
